jxli_fp8mul_host: RTL and testbench
===================================

Name: jxli_fp8mul_host

Overview:
- Host-side initiator for the FP8 (E4M3) nibble-serial multiplier pin protocol.
- Accepts two operand bytes over a valid/ready port and generates the device clock, reset and enable on the 8-bit pin bus.
- Sends A-high, A-low, B-high, B-low nibbles, waits a fixed number of device periods, captures the result byte and returns it over a valid/ready port.
- Sits between system logic (or a bench) and the multiplier's io_in/io_out pins.

Parameters:
- CLK_DIV, 1, system cycles per device-clock half period; must be >= 1.
- WAIT_PERIODS, 32, device periods between the last nibble and result capture; must be >= device worst-case compute latency.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- op_valid  in  1  operand pair offered
- op_ready  out  1  high only in IDLE
- op_a  in  8  operand A, E4M3
- op_b  in  8  operand B, E4M3
- res_valid  out  1  result held valid
- res_ready  in  1  result consumed
- res_data  out  8  captured product byte
- busy  out  1  high in any state other than IDLE
- dut_in  out  8  device pins: [0]=dev clock, [1]=dev reset, [2]=enable, [6:3]=data nibble, [7]=0
- dut_out  in  8  device result pins

Behaviour:
- Reset: the block is reset on clock, when reset is high (synchronous, active-high). Reset values: state IDLE, dut_in=0x00, op_ready=1, res_valid=0, res_data=0x00, busy=0.
- Reset mid-operation: abandon the transaction immediately and drive dut_in=0x00 the next cycle. No result is returned.
- States: IDLE -> DRST -> SAH -> SAL -> SBH -> SBL -> WAIT -> RESP -> IDLE.
- IDLE:
  - op_ready=1; dev clock held low.
  - When op_valid && op_ready at cycle T, latch op_a/op_b and enter DRST.
- Device period:
  - Each non-IDLE/non-RESP state lasts exactly one device period of 2*CLK_DIV system cycles.
  - Dev clock is low for the first CLK_DIV cycles and high for the last CLK_DIV cycles.
  - dut_in[1], [2] and [6:3] change only on the first cycle of a period, giving a half-period setup time before the device rising edge.
- Period k occupies cycles T+1+k*2*CLK_DIV through T+(k+1)*2*CLK_DIV.
- DRST (k=0): rst=1, en=0, data=0. Returns the device to its first-nibble state; device output becomes 0xFF.
- Send states, each one period with en=1, rst=0:
  - SAH, k=1: data=A[7:4]
  - SAL, k=2: data=A[3:0]
  - SBH, k=3: data=B[7:4]
  - SBL, k=4: data=B[3:0]
- WAIT:
  - WAIT_PERIODS periods with en=0, rst=0, data=0; period counter counts down.
  - On the last system cycle of the last WAIT period, register dut_out into res_data, then enter RESP.
- RESP:
  - Dev clock low, dut_in=0x00.
  - res_valid=1 from cycle T+1+(5+WAIT_PERIODS)*2*CLK_DIV; with defaults this is T+75.
  - res_data stable while res_valid is high. On res_valid && res_ready, go to IDLE next cycle.
- Back-to-back: op_ready is low in RESP, so a new operation can be accepted no earlier than the cycle after the handshake. The device is re-reset by every transaction.
- No new operand is accepted while busy; op_valid outside IDLE is ignored.
- Counters:
  - Phase counter, width clog2(2*CLK_DIV), wraps to 0 at 2*CLK_DIV-1.
  - Period counter, width clog2(WAIT_PERIODS+1).
- No data arithmetic: the result byte is passed through unmodified.

Decomposition:
- Shared package jxli_fp8_pkg:
  - host state enum
  - pin index constants (PIN_CLK=0, PIN_RST=1, PIN_EN=2, PIN_DATA_LSB=3)
  - E4M3 constants: NaN magnitude 0x7F, infinity magnitude 0x78
- Sub-module jxli_devclk_gen: phase counter producing dev clock level, period_start and period_end strobes, enabled when busy.

Test Plan (CLK_DIV=1, WAIT_PERIODS=32, real multiplier on pins):
- op_a=0x7F, op_b=0x38 -> dut_in nibble sequence 7,F,3,8 with en=1 on consecutive periods; res_valid at T+75; res_data=0x7F.
- op_a=0x00, op_b=0xB8 -> res_data=0x80 (signed zero); check dut_in[1] high only during cycles T+1..T+2.
- op_a=0x78, op_b=0x00 -> res_data=0x7F (inf*0 = NaN).
- Backpressure: hold res_ready=0 for 10 cycles -> res_valid and res_data stable, op_ready=0, dut_in=0x00; accept then op_ready=1 the next cycle.
- Reset asserted during SAL -> next cycle dut_in=0x00, op_ready=1, res_valid=0; a following 0x78 x 0x38 transaction returns 0x78.
- CLK_DIV=3 -> dev clock 3 low/3 high; nibbles change only on a low-phase first cycle; result at T+1+37*6.

Source files
------------

// File: rtl/jxli_fp8_pkg.sv
// Shared definitions for the FP8 (E4M3) multiplier host.
// Contents: host state encoding, device pin positions on the 8-bit pin bus,
// E4M3 special-value magnitudes, and a helper that packs the pin bus word.
package jxli_fp8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DRST = 3'd1,
        ST_SAH  = 3'd2,
        ST_SAL  = 3'd3,
        ST_SBH  = 3'd4,
        ST_SBL  = 3'd5,
        ST_WAIT = 3'd6,
        ST_RESP = 3'd7
    } host_state_e;

    localparam int PIN_CLK      = 0;
    localparam int PIN_RST      = 1;
    localparam int PIN_EN       = 2;
    localparam int PIN_DATA_LSB = 3;

    localparam logic [6:0] FP8_NAN_MAG = 7'h7F;
    localparam logic [6:0] FP8_INF_MAG = 7'h78;

    // Bit 7 of the pin bus is always driven low.
    function automatic logic [7:0] pin_word(input logic       dclk,
                                            input logic       drst,
                                            input logic       den,
                                            input logic [3:0] nib);
        logic [7:0] w;
        w                     = 8'h00;
        w[PIN_CLK]            = dclk;
        w[PIN_RST]            = drst;
        w[PIN_EN]             = den;
        w[PIN_DATA_LSB +: 4]  = nib;
        return w;
    endfunction

endpackage

// File: rtl/jxli_devclk_gen.sv
// Device clock generator for the FP8 multiplier host.
// A phase counter runs while en_i is high; each device period is 2*CLK_DIV
// system cycles, low for the first CLK_DIV and high for the last CLK_DIV.
// Ports:
//   clock, reset    : system clock, synchronous active-high reset
//   en_i            : run the counter (held at phase 0 while low)
//   dev_clk_o       : registered device clock level
//   period_start_o  : high on the first system cycle of a device period
//   period_end_o    : high on the last system cycle of a device period
module jxli_devclk_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    output logic dev_clk_o,
    output logic period_start_o,
    output logic period_end_o
);

    localparam int PH_W = $clog2(2 * CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_DIV);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;
    logic            dev_clk_q;

    always_comb begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end

    // The clock level is registered from the next phase so the pin never
    // comes from a decode of the counter.
    always_ff @(posedge clock) begin
        if (reset || !en_i) begin
            phase_q   <= '0;
            dev_clk_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            dev_clk_q <= (phase_d >= PH_HIGH);
        end
    end

    assign dev_clk_o      = dev_clk_q;
    assign period_start_o = en_i && (phase_q == '0);
    assign period_end_o   = en_i && (phase_q == PH_LAST);

endmodule

// File: rtl/jxli_fp8mul_host.sv
// Host-side initiator for the nibble-serial FP8 (E4M3) multiplier pins.
// Takes an operand pair over valid/ready, resets the device, sends the four
// operand nibbles (A hi, A lo, B hi, B lo) one device period each, waits
// WAIT_PERIODS device periods, captures dut_out and returns it over
// valid/ready. The result byte is passed through untouched.
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   op_valid/op_ready     : operand handshake (ready only in IDLE)
//   op_a, op_b            : E4M3 operands
//   res_valid/res_ready   : result handshake, res_data held while valid
//   res_data              : captured product byte
//   busy                  : high in every state except IDLE
//   dut_in                : device pins [0]=clk [1]=rst [2]=en [6:3]=nibble
//   dut_out               : device result pins
module jxli_fp8mul_host
    import jxli_fp8_pkg::*;
#(
    parameter int CLK_DIV      = 1,
    parameter int WAIT_PERIODS = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy,
    output logic [7:0] dut_in,
    input  logic [7:0] dut_out
);

    localparam int PW = $clog2(WAIT_PERIODS + 1);

    host_state_e state_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [PW-1:0] wait_q;
    logic [PW-1:0] wait_d;
    logic [7:0]  res_data_q;
    logic        res_valid_q;
    logic        op_ready_q;
    logic        busy_q;
    logic        drst_q;
    logic        den_q;
    logic [3:0]  nib_q;

    logic        gen_en;
    logic        dev_clk;
    logic        period_start;
    logic        period_end;

    // The device clock only runs in the states that occupy device periods.
    assign gen_en = (state_q != ST_IDLE) && (state_q != ST_RESP);

    jxli_devclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_devclk (
        .clock          (clock),
        .reset          (reset),
        .en_i           (gen_en),
        .dev_clk_o      (dev_clk),
        .period_start_o (period_start),
        .period_end_o   (period_end)
    );

    // wait_q holds the WAIT periods still to start; it drops on each period's
    // first cycle, so wait_d is the count of periods left after the current one.
    always_comb begin
        wait_d = period_start ? (wait_q - PW'(1)) : wait_q;
    end

    // Pin control fields are loaded at a period end so they change on the
    // first cycle of the next period, a half period before the device edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            wait_q      <= '0;
            drst_q      <= 1'b0;
            den_q       <= 1'b0;
            nib_q       <= 4'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        state_q    <= ST_DRST;
                        op_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        drst_q     <= 1'b1;
                        den_q      <= 1'b0;
                        nib_q      <= 4'h0;
                    end
                end
                ST_DRST: begin
                    if (period_end) begin
                        state_q <= ST_SAH;
                        drst_q  <= 1'b0;
                        den_q   <= 1'b1;
                        nib_q   <= a_q[7:4];
                    end
                end
                ST_SAH: begin
                    if (period_end) begin
                        state_q <= ST_SAL;
                        nib_q   <= a_q[3:0];
                    end
                end
                ST_SAL: begin
                    if (period_end) begin
                        state_q <= ST_SBH;
                        nib_q   <= b_q[7:4];
                    end
                end
                ST_SBH: begin
                    if (period_end) begin
                        state_q <= ST_SBL;
                        nib_q   <= b_q[3:0];
                    end
                end
                ST_SBL: begin
                    if (period_end) begin
                        state_q <= ST_WAIT;
                        den_q   <= 1'b0;
                        nib_q   <= 4'h0;
                        wait_q  <= PW'(WAIT_PERIODS);
                    end
                end
                ST_WAIT: begin
                    wait_q <= wait_d;
                    if (period_end && (wait_d == '0)) begin
                        res_data_q  <= dut_out;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        op_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_ready  = op_ready_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign dut_in    = pin_word(dev_clk, drst_q, den_q, nib_q);

endmodule

// File: tb/tb_jxli_fp8mul_host.sv
// Bench for jxli_fp8mul_host: two hosts (CLK_DIV=1 and CLK_DIV=3), each wired
// to a behavioural nibble-serial E4M3 multiplier device model.
module tb_jxli_fp8mul_host;
    import jxli_fp8_pkg::*;

    localparam int DEV_LAT = 20;
    localparam int NPER    = 37;   // DRST + 4 send + 32 WAIT periods

    logic       clock;
    logic       reset;
    logic       op_valid  [2];
    logic       op_ready  [2];
    logic [7:0] op_a      [2];
    logic [7:0] op_b      [2];
    logic       res_valid [2];
    logic       res_ready [2];
    logic [7:0] res_data  [2];
    logic       busy      [2];
    logic [7:0] dut_in    [2];
    logic [7:0] dut_out   [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    jxli_fp8mul_host #(.CLK_DIV(1), .WAIT_PERIODS(32)) u_dut0 (
        .clock(clock), .reset(reset),
        .op_valid(op_valid[0]), .op_ready(op_ready[0]),
        .op_a(op_a[0]), .op_b(op_b[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_data(res_data[0]), .busy(busy[0]),
        .dut_in(dut_in[0]), .dut_out(dut_out[0])
    );

    jxli_fp8mul_host #(.CLK_DIV(3), .WAIT_PERIODS(32)) u_dut1 (
        .clock(clock), .reset(reset),
        .op_valid(op_valid[1]), .op_ready(op_ready[1]),
        .op_a(op_a[1]), .op_b(op_b[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_data(res_data[1]), .busy(busy[1]),
        .dut_in(dut_in[1]), .dut_out(dut_out[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- E4M3 reference arithmetic ----------------
    function automatic real fp8_mag(input logic [6:0] m);
        real f;
        int  e;
        e = int'(m[6:3]);
        if (e == 0) return real'(m[2:0]) / 8.0 / 64.0;
        f = 1.0 + real'(m[2:0]) / 8.0;
        for (int i = 7; i < e; i++) f = f * 2.0;
        for (int i = e; i < 7; i++) f = f / 2.0;
        return f;
    endfunction

    // Product rounded to nearest representable value, ties to even code;
    // overflow goes to infinity, NaN inputs and inf*0 give canonical NaN.
    function automatic logic [7:0] fp8_mul(input logic [7:0] a, input logic [7:0] b);
        logic       s;
        logic [6:0] ma;
        logic [6:0] mb;
        real        p;
        real        err;
        real        be;
        int         best;
        s  = a[7] ^ b[7];
        ma = a[6:0];
        mb = b[6:0];
        if (ma > FP8_INF_MAG || mb > FP8_INF_MAG) return {1'b0, FP8_NAN_MAG};
        if ((ma == FP8_INF_MAG && mb == 7'd0) || (mb == FP8_INF_MAG && ma == 7'd0))
            return {1'b0, FP8_NAN_MAG};
        if (ma == FP8_INF_MAG || mb == FP8_INF_MAG) return {s, FP8_INF_MAG};
        p = fp8_mag(ma) * fp8_mag(mb);
        if (p >= 248.0) return {s, FP8_INF_MAG};
        best = 0;
        be   = p;
        for (int c = 1; c < 'h78; c++) begin
            err = fp8_mag(7'(c)) - p;
            if (err < 0.0) err = -err;
            if (err < be || (err == be && (c % 2) == 0)) begin
                best = c;
                be   = err;
            end
        end
        return {s, best[6:0]};
    endfunction

    // ---------------- device models on the pins ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dev
        logic        dclk;
        int          cnt;
        int          lat;
        logic [15:0] sh;
        logic [7:0]  out;
        assign dclk       = dut_in[g][0];
        assign dut_out[g] = out;
        always @(posedge dclk) begin
            if (dut_in[g][1]) begin
                cnt <= 0;
                lat <= 0;
                out <= 8'hFF;
            end else if (dut_in[g][2] && cnt < 4) begin
                sh  <= {sh[11:0], dut_in[g][6:3]};
                cnt <= cnt + 1;
                if (cnt == 3) lat <= DEV_LAT;
            end else if (lat > 1) begin
                lat <= lat - 1;
            end else if (lat == 1) begin
                lat <= 0;
                out <= fp8_mul(sh[15:8], sh[7:0]);
            end
        end
    end

    // ---------------- checking helpers ----------------
    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: pops an expected byte on every result handshake.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && res_valid[0] && res_ready[0]) begin
                if (exp_q0.size() == 0) check("sb0 unexpected result", res_data[0], 32'hDEAD);
                else check("sb0 result", res_data[0], exp_q0.pop_front());
            end
            if (!reset && res_valid[1] && res_ready[1]) begin
                if (exp_q1.size() == 0) check("sb1 unexpected result", res_data[1], 32'hDEAD);
                else check("sb1 result", res_data[1], exp_q1.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    // Offer an operand pair; returns just after the accepting clock edge.
    task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b, input bit push);
        int n;
        @(posedge clock); #2;
        op_a[d] = a;
        op_b[d] = b;
        op_valid[d] = 1'b1;
        n = 0;
        @(negedge clock);
        while (!op_ready[d] && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (!op_ready[d]) check($sformatf("d%0d op_ready wait", d), op_ready[d], 1);
        @(posedge clock); #2;
        op_valid[d] = 1'b0;
        if (push) begin
            if (d == 0) exp_q0.push_back(fp8_mul(a, b));
            else        exp_q1.push_back(fp8_mul(a, b));
        end
    endtask

    task automatic wait_valid(input int d);
        int n;
        n = 0;
        @(negedge clock);
        while (!res_valid[d] && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("d%0d res_valid wait", d), res_valid[d], 1);
    endtask

    // Walk every cycle of a transaction, comparing the pin bus with the
    // period-by-period protocol and res_valid with its arrival cycle.
    task automatic trace(input int d, input logic [7:0] a, input logic [7:0] b, input int cd);
        int         last;
        int         k;
        int         ph;
        logic [7:0] w;
        last = NPER * 2 * cd + 1;
        for (int j = 1; j <= last; j++) begin
            @(negedge clock);
            k  = (j - 1) / (2 * cd);
            ph = (j - 1) % (2 * cd);
            w  = 8'h00;
            if (k < NPER) begin
                w[0] = (ph >= cd);
                w[1] = (k == 0);
                w[2] = (k >= 1 && k <= 4);
                if (k == 1) w[6:3] = a[7:4];
                if (k == 2) w[6:3] = a[3:0];
                if (k == 3) w[6:3] = b[7:4];
                if (k == 4) w[6:3] = b[3:0];
            end
            check($sformatf("d%0d pins T+%0d", d, j), dut_in[d], w);
            check($sformatf("d%0d res_valid T+%0d", d, j), res_valid[d], (j == last));
            if (j == 1) check($sformatf("d%0d busy/op_ready T+1", d), {busy[d], op_ready[d]}, 2'b10);
            if (j == last) check($sformatf("d%0d res_data T+%0d", d, j), res_data[d], fp8_mul(a, b));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            op_valid[d]  = 1'b0;
            op_a[d]      = 8'h00;
            op_b[d]      = 8'h00;
            res_ready[d] = 1'b1;
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset dut_in", d), dut_in[d], 8'h00);
            check($sformatf("d%0d reset op_ready", d), op_ready[d], 1);
            check($sformatf("d%0d reset res_valid", d), res_valid[d], 0);
            check($sformatf("d%0d reset res_data", d), res_data[d], 8'h00);
            check($sformatf("d%0d reset busy", d), busy[d], 0);
        end
        @(posedge clock); #2;
        reset = 1'b0;

        // NaN passthrough, signed zero, inf*0
        issue(0, 8'h7F, 8'h38, 1);
        trace(0, 8'h7F, 8'h38, 1);
        @(negedge clock);
        check("d0 op_ready after handshake", op_ready[0], 1);
        issue(0, 8'h00, 8'hB8, 1);
        trace(0, 8'h00, 8'hB8, 1);
        issue(0, 8'h78, 8'h00, 1);
        trace(0, 8'h78, 8'h00, 1);

        // Backpressure, with a stray op_valid while busy
        @(posedge clock); #2;
        res_ready[0] = 1'b0;
        issue(0, 8'h3C, 8'h44, 1);
        repeat (20) @(negedge clock);
        @(posedge clock); #2;
        op_a[0] = 8'h11;
        op_b[0] = 8'h22;
        op_valid[0] = 1'b1;
        repeat (5) @(posedge clock);
        #2 op_valid[0] = 1'b0;
        wait_valid(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp res_valid", res_valid[0], 1);
            check("bp res_data", res_data[0], fp8_mul(8'h3C, 8'h44));
            check("bp op_ready", op_ready[0], 0);
            check("bp dut_in", dut_in[0], 8'h00);
            check("bp busy", busy[0], 1);
        end
        @(posedge clock); #2;
        res_ready[0] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("bp op_ready after accept", op_ready[0], 1);
        check("bp res_valid after accept", res_valid[0], 0);
        check("bp busy after accept", busy[0], 0);

        // Reset during SAL abandons the transaction
        issue(0, 8'h7F, 8'h38, 0);
        repeat (5) @(negedge clock);
        check("abort in SAL pins", dut_in[0][6:2], {4'hF, 1'b1});
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;
        @(negedge clock);
        check("abort dut_in", dut_in[0], 8'h00);
        check("abort op_ready", op_ready[0], 1);
        check("abort res_valid", res_valid[0], 0);
        check("abort busy", busy[0], 0);
        issue(0, 8'h78, 8'h38, 1);
        trace(0, 8'h78, 8'h38, 1);

        // Slow device clock
        issue(1, 8'h48, 8'hC4, 1);
        trace(1, 8'h48, 8'hC4, 3);

        // Random operands with random result backpressure
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            int         hold;
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(0, 255));
            hold = $urandom_range(0, 3);
            @(posedge clock); #2;
            res_ready[0] = (hold == 0);
            issue(0, a, b, 1);
            wait_valid(0);
            if (hold != 0) begin
                repeat (hold) @(posedge clock);
                #2 res_ready[0] = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            issue(1, a, b, 1);
            wait_valid(1);
        end
        repeat (4) @(negedge clock);
        check("sb0 queue drained", exp_q0.size(), 0);
        check("sb1 queue drained", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
